// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/funct encodings and the ID/EX register bundle.
package mips_pkg;

  localparam int ID_ADDR_W = 28;
  localparam int ID_DATA_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                 valid;
    logic [ID_ADDR_W-1:0] pc;
    logic [5:0]           opcode;
    logic [4:0]           rs;
    logic [4:0]           rt;
    logic [4:0]           rd;
    logic [4:0]           shamt;
    logic [5:0]           funct;
    logic [ID_DATA_W-1:0] imm;
    logic [ID_DATA_W-1:0] rs_data;
    logic [ID_DATA_W-1:0] rt_data;
  } id_ex_t;

  function automatic logic [ID_DATA_W-1:0] sign_extend16(input logic [15:0] imm16);
    return {{(ID_DATA_W-16){imm16[15]}}, imm16};
  endfunction

endpackage

// File: rtl/register_file.sv
// 2-read/1-write register file with asynchronous reads, write-through bypass,
// a hardwired zero register and asynchronous active-low clear.
module register_file
  import mips_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [4:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [4:0]        raddr_a_i,
  input  logic [4:0]        raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != REG_ZERO)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // A write landing on the same edge as the read is forwarded so decode never sees a stale value.
  always_comb begin
    rdata_a_o = regs_q[raddr_a_i];
    if (raddr_a_i == REG_ZERO) begin
      rdata_a_o = '0;
    end else if (we_i && (waddr_i == raddr_a_i)) begin
      rdata_a_o = wdata_i;
    end
  end

  always_comb begin
    rdata_b_o = regs_q[raddr_b_i];
    if (raddr_b_i == REG_ZERO) begin
      rdata_b_o = '0;
    end else if (we_i && (waddr_i == raddr_b_i)) begin
      rdata_b_o = wdata_i;
    end
  end

endmodule

// File: rtl/instruction_decode.sv
// MIPS decode stage: splits the fetched instruction, reads operands and
// registers everything into the ID/EX bundle under stall/flush control.
module instruction_decode
  import mips_pkg::*;
#(
  parameter int ADDR_W   = 28,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              if_ready,
  input  logic              id_stall,
  input  logic              id_flush,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [5:0]        id_opcode,
  output logic [4:0]        id_rs,
  output logic [4:0]        id_rt,
  output logic [4:0]        id_rd,
  output logic [4:0]        id_shamt,
  output logic [5:0]        id_funct,
  output logic [DATA_W-1:0] id_imm,
  output logic [DATA_W-1:0] id_rs_data,
  output logic [DATA_W-1:0] id_rt_data
);

  id_ex_t            id_q, id_d, fresh;
  logic [DATA_W-1:0] rs_rd_data, rt_rd_data;

  register_file #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we_i      (wb_we),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .raddr_a_i (if_instr[25:21]),
    .raddr_b_i (if_instr[20:16]),
    .rdata_a_o (rs_rd_data),
    .rdata_b_o (rt_rd_data)
  );

  assign if_ready = ~id_stall;

  always_comb begin
    fresh         = '0;
    fresh.valid   = if_valid;
    fresh.pc      = if_pc;
    fresh.opcode  = if_instr[31:26];
    fresh.rs      = if_instr[25:21];
    fresh.rt      = if_instr[20:16];
    fresh.rd      = if_instr[15:11];
    fresh.shamt   = if_instr[10:6];
    fresh.funct   = if_instr[5:0];
    fresh.imm     = sign_extend16(if_instr[15:0]);
    fresh.rs_data = rs_rd_data;
    fresh.rt_data = rt_rd_data;
  end

  // Flush beats stall; a held instruction still picks up write-back results so a load-use stall resolves cleanly.
  always_comb begin
    id_d = id_q;
    if (id_flush) begin
      id_d       = fresh;
      id_d.valid = 1'b0;
    end else if (id_stall) begin
      if (wb_we && (wb_addr != REG_ZERO) && (wb_addr == id_q.rs)) begin
        id_d.rs_data = wb_data;
      end
      if (wb_we && (wb_addr != REG_ZERO) && (wb_addr == id_q.rt)) begin
        id_d.rt_data = wb_data;
      end
    end else begin
      id_d = fresh;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_q <= '0;
    end else begin
      id_q <= id_d;
    end
  end

  assign id_valid   = id_q.valid;
  assign id_pc      = id_q.pc;
  assign id_opcode  = id_q.opcode;
  assign id_rs      = id_q.rs;
  assign id_rt      = id_q.rt;
  assign id_rd      = id_q.rd;
  assign id_shamt   = id_q.shamt;
  assign id_funct   = id_q.funct;
  assign id_imm     = id_q.imm;
  assign id_rs_data = id_q.rs_data;
  assign id_rt_data = id_q.rt_data;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed testbench for instruction_decode with hand-computed expectations.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [27:0] if_pc;
  logic        if_ready;
  logic        id_stall;
  logic        id_flush;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        id_valid;
  logic [27:0] id_pc;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [5:0]  id_funct;
  logic [31:0] id_imm, id_rs_data, id_rt_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instruction_decode dut (
    .clk        (clk),
    .rst        (rst),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_ready   (if_ready),
    .id_stall   (id_stall),
    .id_flush   (id_flush),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_opcode  (id_opcode),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rd      (id_rd),
    .id_shamt   (id_shamt),
    .id_funct   (id_funct),
    .id_imm     (id_imm),
    .id_rs_data (id_rs_data),
    .id_rt_data (id_rt_data)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [27:0] pc,
                               input logic stall, input logic flush,
                               input logic we, input logic [4:0] wa, input logic [31:0] wd);
    if_valid = v;
    if_instr = instr;
    if_pc    = pc;
    id_stall = stall;
    id_flush = flush;
    wb_we    = we;
    wb_addr  = wa;
    wb_data  = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 28'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    #2;
    checkOutput("rst_valid", {31'b0, id_valid}, 32'h0);
    checkOutput("rst_pc", {4'b0, id_pc}, 32'h0);
    checkOutput("rst_ready", {31'b0, if_ready}, 32'h1);
    #10;
    rst = 1'b1;
    tick();

    // Load $9=5 and $10=7 through write-back.
    applyStimulus(1'b0, 32'h0, 28'h0, 1'b0, 1'b0, 1'b1, 5'd9, 32'd5);
    tick();
    checkOutput("novalid", {31'b0, id_valid}, 32'h0);
    applyStimulus(1'b0, 32'h0, 28'h0, 1'b0, 1'b0, 1'b1, 5'd10, 32'd7);
    tick();

    // R-type add $8,$9,$10.
    applyStimulus(1'b1, 32'h012A4020, 28'h10, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("r_valid", {31'b0, id_valid}, 32'h1);
    checkOutput("r_opcode", {26'b0, id_opcode}, 32'h0);
    checkOutput("r_rs", {27'b0, id_rs}, 32'd9);
    checkOutput("r_rt", {27'b0, id_rt}, 32'd10);
    checkOutput("r_rd", {27'b0, id_rd}, 32'd8);
    checkOutput("r_shamt", {27'b0, id_shamt}, 32'd0);
    checkOutput("r_funct", {26'b0, id_funct}, 32'h20);
    checkOutput("r_rsdata", id_rs_data, 32'd5);
    checkOutput("r_rtdata", id_rt_data, 32'd7);
    checkOutput("r_pc", {4'b0, id_pc}, 32'h10);

    // addi $8,$9,-4 with a same-edge write to $9.
    applyStimulus(1'b1, 32'h2128FFFC, 28'h14, 1'b0, 1'b0, 1'b1, 5'd9, 32'h64);
    tick();
    checkOutput("i_opcode", {26'b0, id_opcode}, 32'h08);
    checkOutput("i_imm", id_imm, 32'hFFFFFFFC);
    checkOutput("i_rs", {27'b0, id_rs}, 32'd9);
    checkOutput("i_bypass", id_rs_data, 32'h64);
    checkOutput("i_rtdata", id_rt_data, 32'h0);

    // Writes to $0 are discarded, including a same-edge bypass attempt.
    applyStimulus(1'b0, 32'h0, 28'h18, 1'b0, 1'b0, 1'b1, 5'd0, 32'hDEADBEEF);
    tick();
    applyStimulus(1'b1, 32'h20010005, 28'h1C, 1'b0, 1'b0, 1'b1, 5'd0, 32'hDEADBEEF);
    tick();
    checkOutput("z_rsdata", id_rs_data, 32'h0);
    checkOutput("z_imm", id_imm, 32'h5);
    checkOutput("z_rt", {27'b0, id_rt}, 32'd1);

    // Stall: hold add $8,$9,$10 while fetch presents lw.
    applyStimulus(1'b1, 32'h012A4020, 28'h10, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("s_pre_rs", id_rs_data, 32'h64);
    applyStimulus(1'b1, 32'h8D2B0004, 28'h14, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("s_ready", {31'b0, if_ready}, 32'h0);
    tick();
    checkOutput("s1_opcode", {26'b0, id_opcode}, 32'h0);
    checkOutput("s1_rd", {27'b0, id_rd}, 32'd8);
    checkOutput("s1_pc", {4'b0, id_pc}, 32'h10);
    applyStimulus(1'b1, 32'h8D2B0004, 28'h14, 1'b1, 1'b0, 1'b1, 5'd10, 32'h1234);
    tick();
    checkOutput("s2_rtdata", id_rt_data, 32'h1234);
    checkOutput("s2_rsdata", id_rs_data, 32'h64);
    checkOutput("s2_pc", {4'b0, id_pc}, 32'h10);
    applyStimulus(1'b1, 32'h8D2B0004, 28'h14, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("rel_ready", {31'b0, if_ready}, 32'h1);
    tick();
    checkOutput("rel_opcode", {26'b0, id_opcode}, 32'h23);
    checkOutput("rel_pc", {4'b0, id_pc}, 32'h14);
    checkOutput("rel_rt", {27'b0, id_rt}, 32'd11);
    checkOutput("rel_imm", id_imm, 32'h4);

    // Flush together with stall; the write to $11 still lands.
    applyStimulus(1'b1, 32'h8D2B0004, 28'h18, 1'b1, 1'b1, 1'b1, 5'd11, 32'hCAFE);
    tick();
    checkOutput("f_valid", {31'b0, id_valid}, 32'h0);
    applyStimulus(1'b1, 32'h8D2B0004, 28'h18, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("f_rtdata", id_rt_data, 32'hCAFE);
    checkOutput("f_valid2", {31'b0, id_valid}, 32'h1);

    // Asynchronous reset mid-stream, then register file must read back zero.
    #2;
    rst = 1'b0;
    #1;
    checkOutput("ar_valid", {31'b0, id_valid}, 32'h0);
    checkOutput("ar_rtdata", id_rt_data, 32'h0);
    checkOutput("ar_opcode", {26'b0, id_opcode}, 32'h0);
    tick();
    rst = 1'b1;
    applyStimulus(1'b1, 32'h8D2B0004, 28'h14, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("ar_rs_cleared", id_rs_data, 32'h0);
    checkOutput("ar_rt_cleared", id_rt_data, 32'h0);
    checkOutput("ar_valid2", {31'b0, id_valid}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
MIPS decode stage, directly downstream of the instruction fetch stage. It consumes the fetched 32-bit instruction and its 28-bit PC, splits the instruction into fields, reads two operands from an internal 32x32 register file, and sign-extends the immediate. All results go into an ID/EX output register, with stall and flush control from the hazard logic and a write port from write-back.

Parameters:
ADDR_W, 28, PC/instruction-memory address width (matches fetch stage)
DATA_W, 32, instruction and register data width
NUM_REGS, 32, register file depth (5-bit index)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
if_valid  in  1  fetch presents a valid instruction this cycle
if_instr  in  32  instruction from instruction memory
if_pc  in  ADDR_W  address of if_instr
if_ready  out  1  decode accepts input this cycle (= ~id_stall)
id_stall  in  1  hazard unit: hold ID/EX register and fetch PC
id_flush  in  1  hazard/branch: squash instruction entering ID/EX
wb_we  in  1  write-back register write enable
wb_addr  in  5  write-back destination register
wb_data  in  DATA_W  write-back data
id_valid  out  1  ID/EX holds a live instruction
id_pc  out  ADDR_W  PC of decoded instruction
id_opcode  out  6  instr[31:26]
id_rs, id_rt, id_rd  out  5 each  instr[25:21], [20:16], [15:11]
id_shamt  out  5  instr[10:6]
id_funct  out  6  instr[5:0]
id_imm  out  DATA_W  sign-extended instr[15:0]
id_rs_data, id_rt_data  out  DATA_W  register operands

Behaviour:
- Reset (rst=0, asynchronous): every output register is 0, including id_valid and all fields/data. All register-file entries are cleared to 0. Reset asserted mid-operation discards the in-flight instruction immediately, with no clock needed.
- Latency: one cycle. Inputs sampled at edge N appear on the id_* outputs after edge N.
- Capture rule per rising edge, in priority order:
  1. id_flush=1: id_valid<=0; other fields may load but are don't-care. Flush beats stall.
  2. id_stall=1: all id_* outputs hold, except the operand refresh below.
  3. Otherwise: id_valid<=if_valid. Fields, id_pc, id_imm and operands load from the current inputs regardless of if_valid.
- if_ready = ~id_stall, combinational. The fetch stage must not advance its PC while if_ready=0.
- Register file:
  - Two asynchronous read ports (rs, rt) and one synchronous write port.
  - Register 0 always reads 0; writes to it are ignored.
  - A write on the same edge as capture is bypassed: if wb_we and wb_addr==rs (nonzero), the captured rs_data is wb_data. rt uses the same rule.
- Stall operand refresh: while stalled, if wb_we and wb_addr is nonzero and equal to the held id_rs (or id_rt), the held id_rs_data (or id_rt_data) updates to wb_data. This prevents stale operands after a load-use stall.
- id_imm = {{16{instr[15]}}, instr[15:0]}. There is no zero-extension in this block; the execute stage selects that form if needed.
- Simultaneous id_stall and id_flush: flush wins and id_valid clears. Write-back still updates the register file.

Decomposition:
- Package mips_pkg holds:
  - opcode and funct localparams (OP_RTYPE=6'h00, OP_ADDI=6'h08, OP_LW=6'h23, OP_SW=6'h2B, OP_BEQ=6'h04, OP_J=6'h02; FN_ADD=6'h20, FN_SUB=6'h22, ...)
  - REG_ZERO=5'd0
  - a packed struct id_ex_t for the output register bundle
- One sub-module, register_file: 2R/1W, async read, sync write, write-through bypass, zero register, async active-low clear.

Test Plan:
- Reset: hold rst=0 mid-stream → all outputs 0 and id_valid=0 immediately. After release, reading any register returns 0.
- R-type: write $9=5 and $10=7 via WB, then if_instr=0x012A4020 with if_pc=0x0000010 → next cycle opcode=0, rs=9, rt=10, rd=8, shamt=0, funct=0x20, rs_data=5, rt_data=7, id_pc=0x10, id_valid=1.
- I-type plus bypass: if_instr=0x2128FFFC while the same edge has wb_we=1, wb_addr=9, wb_data=0x64 → id_imm=0xFFFFFFFC, rs=9, rs_data=0x64.
- Zero register: wb_we=1, wb_addr=0, wb_data=0xDEADBEEF, then decode an instruction reading $0 → rs_data=0.
- Stall: hold id_stall=1 for 2 cycles with new if_instr values → outputs unchanged and if_ready=0. A WB to the held rt with 0x1234 during the stall → id_rt_data=0x1234. On release, the next instruction loads.
- Flush: id_flush=1 together with id_stall=1 and if_valid=1 → id_valid=0 next cycle. A register write on that same edge still lands.
